// File: rtl/serial_pattern_tx_pkg.sv
// Shared constants and helpers for the serial pattern transmitter.
package serial_pattern_tx_pkg;

  localparam int GAP_CNT_W = 4;

  // A counter for WIDTH=2 still needs one bit, so never return zero.
  function automatic int cnt_width(input int width);
    return (width > 32'sd2) ? $clog2(width) : 32'sd1;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_piso_shift_reg.sv
// Parallel-in, serial-out shift register, MSB first.
// q_next exposes the bit that becomes the MSB after the next shift.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb,
  output logic             q_next
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next contents: load wins over shift, zeros fill from the LSB side.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      sr_d = sr_q;
    end
  end

  // Register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q <= {WIDTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_msb  = sr_q[WIDTH-1];
  assign q_next = sr_q[WIDTH-2];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: sends a WIDTH-bit word MSB first, one bit per en strobe,
// then holds the line high for GAP_BITS strobes and pulses done.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int GAP_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             a_out,
  output logic             a_valid,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  if (WIDTH < 32'sd2 || WIDTH > 32'sd32) begin : g_bad_width
    $error("serial_pattern_tx: WIDTH=%0d outside 2..32", WIDTH);
  end
  if (GAP_BITS < 32'sd0 || GAP_BITS > 32'sd15) begin : g_bad_gap
    $error("serial_pattern_tx: GAP_BITS=%0d outside 0..15", GAP_BITS);
  end

  state_e               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 a_out_q, a_out_d;
  logic                 a_valid_q, a_valid_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 load, shift, q_msb, q_next;

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .shift  (shift),
    .d      (data),
    .q_msb  (q_msb),
    .q_next (q_next)
  );

  // Next-state logic; ready stays low in the done cycle so a start there is dropped.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    a_out_d   = a_out_q;
    a_valid_d = a_valid_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && ready_q) begin
          load      = 1'b1;
          state_d   = S_SEND;
          bit_cnt_d = CW'(WIDTH - 1);
          a_out_d   = data[WIDTH-1];
          a_valid_d = 1'b1;
          ready_d   = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_SEND: begin
        if (!en) begin
          a_out_d = q_msb;
        end else if (bit_cnt_q != {CW{1'b0}}) begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_q - CW'(1);
          a_out_d   = q_next;
        end else if (GAP_BITS > 32'sd0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_CNT_W'(GAP_BITS - 1);
          a_out_d   = 1'b1;
          a_valid_d = 1'b0;
        end else begin
          state_d   = S_IDLE;
          a_out_d   = 1'b1;
          a_valid_d = 1'b0;
          ready_d   = 1'b0;
          done_d    = 1'b1;
        end
      end
      S_GAP: begin
        if (!en) begin
          gap_cnt_d = gap_cnt_q;
        end else if (gap_cnt_q != {GAP_CNT_W{1'b0}}) begin
          gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = {CW{1'b0}};
        gap_cnt_d = {GAP_CNT_W{1'b0}};
        a_out_d   = 1'b1;
        a_valid_d = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  // State, counters and outputs, all with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= {CW{1'b0}};
      gap_cnt_q <= {GAP_CNT_W{1'b0}};
      a_out_q   <= 1'b1;
      a_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      a_out_q   <= a_out_d;
      a_valid_q <= a_valid_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign a_out   = a_out_q;
  assign a_valid = a_valid_q;
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: vector table, directed corner sequences,
// random traffic against a strobe-counting reference model, and a loopback detector.
module tb_serial_pattern_tx;

  localparam int W = 8;
  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, en, start;
  logic [W-1:0] data;
  logic         ready, a_out, a_valid, done;

  logic         reset0, en0, start0;
  logic [W-1:0] data0;
  logic         ready0, a_out0, a_valid0, done0;

  serial_pattern_tx #(.WIDTH(W), .GAP_BITS(G)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .data(data),
    .ready(ready), .a_out(a_out), .a_valid(a_valid), .done(done)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP_BITS(0)) dut0 (
    .clk(clk), .reset(reset0), .en(en0), .start(start0), .data(data0),
    .ready(ready0), .a_out(a_out0), .a_valid(a_valid0), .done(done0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a frame is "strobes counted since accept"; bit k of the frame
  // is on the line until the k+1th strobe, then W+G strobes end the frame.
  logic         m_busy = 1'b0;
  int           m_k = 0;
  logic [W-1:0] m_word = '0;
  logic         m_a = 1'b1, m_valid = 1'b0, m_ready = 1'b1, m_done = 1'b0;

  task automatic model_step();
    logic pr;
    pr     = m_ready;
    m_done = 1'b0;
    if (!reset) begin
      m_busy  = 1'b0;
      m_ready = 1'b1;
    end else if (m_busy) begin
      m_ready = 1'b0;
      if (en) begin
        m_k++;
        if (m_k == W + G) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (start && pr) begin
      m_busy  = 1'b1;
      m_k     = 0;
      m_word  = data;
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
    m_valid = m_busy && (m_k < W);
    m_a     = m_valid ? m_word[W-1-m_k] : 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step_chk(input string name);
    step();
    chk({name, " a/v/r/d"}, {28'd0, a_out, a_valid, ready, done},
        {28'd0, m_a, m_valid, m_ready, m_done});
  endtask

  typedef struct {
    logic         rst, en, start;
    logic [W-1:0] data;
    logic         a, v, r, d;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic e, input logic s, input logic [W-1:0] dt,
                              input logic a, input logic v, input logic r, input logic d);
    vec_t x;
    x.rst = rs; x.en = e; x.start = s; x.data = dt;
    x.a = a; x.v = v; x.r = r; x.d = d;
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] frame;
    int           valid_cnt, dn, flags, dones;
    logic         got_done, prev_bit;

    reset = 1'b0; en = 1'b0; start = 1'b0; data = '0;
    reset0 = 1'b0; en0 = 1'b0; start0 = 1'b0; data0 = '0;

    // Reset held with start=1, then frame 1010_0110 at full rate, then corner rows.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'hA6, 1'b1, 1'b1, 1'b0, 1'b0));
    frame = 8'hA6;
    for (int b = 6; b >= 0; b--) vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, frame[b], 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; en = vecs[i].en; start = vecs[i].start; data = vecs[i].data;
      step();
      chk($sformatf("vec%0d a/v/r/d", i), {28'd0, a_out, a_valid, ready, done},
          {28'd0, vecs[i].a, vecs[i].v, vecs[i].r, vecs[i].d});
    end

    // Slow strobe: en every 4th cycle, counted from the accept cycle.
    start = 1'b0; en = 1'b0; step_chk("t3_idle");
    start = 1'b1; data = 8'h81; en = 1'b1; step_chk("t3_accept");
    start = 1'b0;
    valid_cnt = int'(a_valid);
    got_done  = 1'b0;
    for (int c = 1; c <= 60 && !got_done; c++) begin
      en = (c % 4 == 0);
      step_chk("t3_frame");
      if (a_valid) valid_cnt++;
      if (done) begin
        got_done = 1'b1;
        chk("t3_done_latency", c, 40);
      end
    end
    chk("t3_done_seen", {31'd0, got_done}, 32'd1);
    chk("t3_valid_cycles", valid_cnt, 32);

    // Start pulsed mid-frame with different data must be ignored.
    en = 1'b1; step_chk("t4_wait");
    start = 1'b1; data = 8'h5A; step_chk("t4_accept");
    start = 1'b0;
    dn = 0;
    for (int c = 1; c <= 16; c++) begin
      start = (c == 3);
      data  = (c == 3) ? 8'hFF : 8'h00;
      step_chk("t4_frame");
      if (done) dn++;
    end
    chk("t4_done_count", dn, 1);

    // Reset mid-frame aborts without done; a new frame then runs cleanly.
    start = 1'b1; data = 8'h96; en = 1'b1; step_chk("t5_accept");
    start = 1'b0;
    for (int c = 1; c <= 5; c++) step_chk("t5_send");
    reset = 1'b0; step_chk("t5_reset");
    chk("t5_ready_after_reset", {31'd0, ready}, 32'd1);
    chk("t5_line_after_reset", {31'd0, a_out}, 32'd1);
    chk("t5_no_done", {31'd0, done}, 32'd0);
    reset = 1'b1; start = 1'b1; data = 8'hC3; step_chk("t5_restart");
    start = 1'b0;
    dn = 0;
    for (int c = 1; c <= 12; c++) begin
      step_chk("t5_frame");
      if (done) dn++;
    end
    chk("t5_done_count", dn, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      en    = ($urandom_range(0, 2) != 0);
      start = ($urandom_range(0, 3) == 0);
      data  = W'($urandom);
      step_chk("rand");
    end

    // Loopback into a 0-then-1 detector with back-to-back GAP_BITS=0 frames.
    reset = 1'b1; en = 1'b0; start = 1'b0;
    reset0 = 1'b0; step_chk("t6_reset");
    reset0 = 1'b1; en0 = 1'b1; start0 = 1'b1; data0 = 8'h55;
    prev_bit = 1'b1; flags = 0; dones = 0;
    for (int c = 0; c < 100 && dones < 3; c++) begin
      step_chk("t6_main_idle");
      if (!prev_bit && a_out0) flags++;
      prev_bit = a_out0;
      if (done0) dones++;
    end
    chk("t6_done_count", dones, 3);
    chk("t6_detector_flags", flags, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
